dac712_interface: RTL and testbench

//   Parallel-bus front end for a TI DAC712 16-bit DAC.
//   - Registers a 16-bit code from the control datapath onto the DAC data pins.
//   - Drives the DAC control lines {A1,A2,WR,CLR} so the input latch stays transparent.
//   - Sits between the controller output stage and the board-level DAC pins.
//   - Every output is registered, so the DAC sees glitch-free, clock-aligned levels.

---
 rtl/dac712_interface.sv | 39 +++
 tb/tb_dac712_interface.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dac712_interface.sv
// Parallel-bus front end for a TI DAC712: registers the 16-bit code onto the DAC
// data pins and holds the control lines {A1,A2,WR,CLR} in the transparent-latch code.
module dac712_interface #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter logic [3:0]  LATCH_TRANSPARENT = 4'b1101,
  parameter logic [3:0]  DO_NOTHING        = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] send_value,
  output logic [DATA_WIDTH-1:0] dac_output,
  output logic [3:0]            ic_com
);

  // Hold mode is reserved for a later revision; the latch is always kept transparent.
  localparam logic HOLD_MODE = 1'b0;

  logic [DATA_WIDTH-1:0] dac_output_q, dac_output_d;
  logic [3:0]            ic_com_q, ic_com_d;

  always_comb begin
    dac_output_d = send_value;
    ic_com_d     = HOLD_MODE ? DO_NOTHING : LATCH_TRANSPARENT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_output_q <= '0;
      ic_com_q     <= LATCH_TRANSPARENT;
    end else begin
      dac_output_q <= dac_output_d;
      ic_com_q     <= ic_com_d;
    end
  end

  assign dac_output = dac_output_q;
  assign ic_com     = ic_com_q;

endmodule

// File: tb/tb_dac712_interface.sv
// Self-checking bench for dac712_interface: a scoreboard queue of driven codes
// predicts the DAC bus one cycle later; the control bus must stay at 4'b1101.
module tb_dac712_interface;

  localparam logic [3:0] EXP_COM = 4'b1101;

  logic        clk;
  logic        rst;
  logic [15:0] send_value;
  logic [15:0] dac_output;
  logic [3:0]  ic_com;

  int tests_run;
  int tests_failed;

  // Codes captured at each rising edge, oldest first.
  logic [15:0] sb_q[$];

  dac712_interface dut (
    .clk        (clk),
    .rst        (rst),
    .send_value (send_value),
    .dac_output (dac_output),
    .ic_com     (ic_com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one code, let one rising edge pass, sample 1 time unit later.
  task automatic drive_cycle(input logic [15:0] v, input string name);
    logic [15:0] exp_v;
    send_value = v;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    tests_run++;
    if (dac_output !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: dac_output=%h expected=%h", name, dac_output, exp_v);
    end
    tests_run++;
    if (ic_com !== EXP_COM) begin
      tests_failed++;
      $display("FAIL %s ic_com: got=%b expected=%b", name, ic_com, EXP_COM);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    send_value = 16'h5555;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (dac_output !== 16'h0000 || ic_com !== EXP_COM) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: dac_output=%h ic_com=%b expected 0000/%b",
                 i, dac_output, ic_com, EXP_COM);
      end
    end
    rst = 1'b0;
    $display("[TB] reset held 3 cycles with send_value=5555");
  endtask

  task automatic test_first_value();
    for (int i = 0; i < 2; i++) drive_cycle(16'h1234, "first_value");
    $display("[TB] first value 1234 after reset release");
  endtask

  task automatic test_fixed_codes();
    logic [15:0] codes [9];
    codes = '{16'h5678, 16'h9ABC, 16'hDEF0, 16'h0000, 16'hFFFF,
              16'h8000, 16'h5555, 16'hAAAA, 16'h0001};
    foreach (codes[k]) begin
      drive_cycle(codes[k], "fixed_code");
      drive_cycle(codes[k], "fixed_code_hold");
      $display("[TB] fixed code %h held 2 cycles", codes[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int i = 0; i < 10; i++) begin
      v = 16'(i * 1000);
      drive_cycle(v, "step");
      $display("[TB] step i=%0d send_value=%h", i, v);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom);
      drive_cycle(v, "random");
      $display("[TB] random #%0d send_value=%h", i, v);
    end
  endtask

  // Changing the input between edges must not reach the output.
  task automatic test_no_comb_path();
    logic [15:0] held;
    drive_cycle(16'h3C3C, "no_comb_setup");
    held = 16'h3C3C;
    send_value = 16'hC3C3;
    #2;
    tests_run++;
    if (dac_output !== held) begin
      tests_failed++;
      $display("FAIL no_comb_path: dac_output=%h expected=%h", dac_output, held);
    end
    sb_q.push_back(16'hC3C3);
    @(posedge clk);
    #1;
    held = sb_q.pop_front();
    tests_run++;
    if (dac_output !== held) begin
      tests_failed++;
      $display("FAIL no_comb_path next edge: dac_output=%h expected=%h", dac_output, held);
    end
    $display("[TB] mid-cycle input change isolated from output");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) drive_cycle(16'h7777, "hold_7777");
    $display("[TB] hold 7777 for 5 cycles");
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (dac_output !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset: dac_output=%h expected=0000", dac_output);
    end
    tests_run++;
    if (ic_com !== EXP_COM) begin
      tests_failed++;
      $display("FAIL async_reset ic_com: got=%b expected=%b", ic_com, EXP_COM);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    drive_cycle(16'hBEEF, "post_reset");
    $display("[TB] async reset mid-stream cleared output, then BEEF loaded");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_first_value();
    test_fixed_codes();
    test_back_to_back();
    test_random_stream();
    test_no_comb_path();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
